time_entry_ctrl: RTL and testbench
==================================

# time_entry_ctrl

Sequencing controller for manual time setting in the alarm/nap clock. Turns debounced keypad digit presses, `sharp` (confirm) and `star` (clear) into validated BCD hour/minute/second fields, walking the user through hour → minute → second. It sits between the keypad front-end and the timekeeping counter: it drives the display digits during entry and issues a one-cycle `load` to the counter on commit. It replaces ad-hoc shift-register/enable wiring with range checking, abort-on-timeout and restore of the previously committed time.

## Interface
- `TIMEOUT_CYCLES`, 1000: idle cycles in an entry state before the session aborts.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  level; high in IDLE starts an entry session.
- `keypad`  in  10  one-hot digit keys, bit n = digit n; debounced and synchronous to `clk`.
- `sharp`  in  1  confirm key, level, debounced.
- `star`  in  1  clear key, level, debounced.
- `hour_ten`, `hour_one`, `min_ten`, `min_one`, `sec_ten`, `sec_one`  out  4 each  staged BCD digits.
- `field`  out  2  active field: 0 hour, 1 min, 2 sec, 3 none.
- `busy`  out  1  high while in HOUR/MIN/SEC/COMMIT.
- `load`  out  1  one-cycle pulse; the digits are the new time on that cycle.
- `err`  out  1  one-cycle pulse on a rejected field.

## Operation
- Press events are rising edges. A digit press is `keypad` exactly one-hot in the current cycle and all-zero in the previous cycle. Multi-hot patterns are ignored and do not count as a release. `sharp` and `star` are each edge-detected.
- Same-cycle priority: sharp > star > digit. A lower-priority event in the same cycle is dropped.
- States:
  - IDLE → HOUR when `en` is high. Staged digits keep the committed values and the digit count is 0.
  - HOUR, MIN, SEC handle events as follows:
    - Digit d: if count = 0, field ← {0,d}. Otherwise field ← {old ones, d}; the tens digit is shifted out, so the last two digits win. Count saturates at 2.
    - Star: field ← 00, count ← 0.
    - Sharp: compute value = ten·10 + one. Limits are ≤23 for hour and ≤59 for min/sec. If in range, go to the next state (HOUR→MIN→SEC→COMMIT) with count ← 0. If out of range, pulse `err`, set field ← 00 and stay in the current state.
  - COMMIT: for one cycle, `load`=1. The shadow (committed) registers ← staged digits. Then go to IDLE.
- Timeout: a counter clears on every accepted event and on state entry. When it reaches `TIMEOUT_CYCLES` in HOUR/MIN/SEC, staged digits are restored from the shadow, `load` stays 0, and the state goes to IDLE.
- `en` is ignored outside IDLE.
- Sharp with count = 0 confirms the existing field value unchanged.

## Timing
- Reset: all digits and shadow registers 0, `field`=3, `busy`=0, `load`=0, `err`=0, state IDLE, edge-history registers 0.
- An event in cycle t updates the staged digits, state and `err` at the edge ending t. They are visible in cycle t+1.
- `en` high in cycle t gives `busy`=1 and `field`=0 in t+1.
- SEC sharp accepted in cycle t gives `load`=1 in t+1 and `busy`=0 in t+2.
- `err` is high for exactly one cycle per rejection. Back-to-back rejections require separate presses.
- Timeout fires on the edge where the counter equals `TIMEOUT_CYCLES`−1 after the last event. Restored digits are visible on the next cycle.
- `rst` mid-session returns everything to reset values immediately. The shadow is cleared too.
- A key held across a state change produces no new event until it is released and pressed again.

## Structure
- Shared package `time_entry_pkg` holds:
  - state encoding IDLE/HOUR/MIN/SEC/COMMIT;
  - field codes 0–3;
  - constants HOUR_MAX=23 and MINSEC_MAX=59.
- Sub-module `key_edge_det`: registers the previous key level and outputs a press pulse. It is instantiated for the keypad (with the one-hot check), `sharp` and `star`.
- The FSM, digit shifting, range check, shadow registers and timeout counter live in `time_entry_ctrl`.

## Test plan
- Happy path: en; press 1, 2, sharp; 3, 4, sharp; 5, 6, sharp → `load` pulses once with 12:34:56 and returns to IDLE with `busy`=0.
- Range rejection: hour 2, 5, sharp → `err` pulses, hour=00, `field` stays 0. Then 0, 9, sharp → advances to min.
- Shift and clear: in min, press 1, 2, 3 → 23; star → 00; 4, sharp → 04 accepted.
- Timeout: committed 07:00:00. Enter hour 1, then no keys for TIMEOUT_CYCLES → digits back to 07:00:00, no `load`, IDLE.
- Simultaneity: sharp and digit 5 in the same cycle → only the confirm occurs. A two-hot keypad pattern produces no digit.
- Reset mid-entry: assert `rst` in SEC → all outputs 0, `field`=3, and a new session starts cleanly.

Source files
------------

// File: rtl/time_entry_pkg.sv
// Shared encodings and limits for the manual time-entry controller.
package time_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOUR,
    ST_MIN,
    ST_SEC,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FLD_HOUR = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_SEC  = 2'd2;
  localparam logic [1:0] FLD_NONE = 2'd3;

  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  // Callers only use this on a one-hot vector.
  function automatic logic [3:0] onehot_to_bcd(input logic [9:0] k);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++)
      if (k[i]) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Rising-edge press detector; in one-hot mode only a clean single key
// rising out of an all-released vector counts as a press.
module key_edge_det #(
  parameter int W       = 1,
  parameter bit ONE_HOT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic         press
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= level;
  end

  generate
    if (ONE_HOT) begin : g_onehot
      assign press = $onehot(level) && (prev == '0);
    end else begin : g_level
      assign press = |(level & ~prev);
    end
  endgenerate

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad-driven hour/minute/second entry with range check, timeout abort
// and restore of the last committed time.
module time_entry_ctrl
  import time_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] keypad,
  input  logic       sharp,
  input  logic       star,
  output logic [3:0] hour_ten,
  output logic [3:0] hour_one,
  output logic [3:0] min_ten,
  output logic [3:0] min_one,
  output logic [3:0] sec_ten,
  output logic [3:0] sec_one,
  output logic [1:0] field,
  output logic       busy,
  output logic       load,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t      state, nxt_state;
  logic        key_p, sharp_p, star_p;
  logic [1:0]  count, nxt_count;
  logic [TW-1:0] tmo;
  logic [3:0]  cur_ten, cur_one, nxt_ten, nxt_one;
  logic [6:0]  val, limit;
  logic        evt, err_set, restore;
  logic [3:0]  sh_hour_ten, sh_hour_one, sh_min_ten, sh_min_one, sh_sec_ten, sh_sec_one;

  key_edge_det #(.W(10), .ONE_HOT(1'b1)) u_key   (.clk(clk), .rst(rst), .level(keypad), .press(key_p));
  key_edge_det #(.W(1),  .ONE_HOT(1'b0)) u_sharp (.clk(clk), .rst(rst), .level(sharp),  .press(sharp_p));
  key_edge_det #(.W(1),  .ONE_HOT(1'b0)) u_star  (.clk(clk), .rst(rst), .level(star),   .press(star_p));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    cur_ten = 4'd0;
    cur_one = 4'd0;
    case (state)
      ST_HOUR: begin cur_ten = hour_ten; cur_one = hour_one; end
      ST_MIN:  begin cur_ten = min_ten;  cur_one = min_one;  end
      ST_SEC:  begin cur_ten = sec_ten;  cur_one = sec_one;  end
      default: ;
    endcase
  end

  assign val   = 7'(cur_ten) * 7'd10 + 7'(cur_one);
  assign limit = (state == ST_HOUR) ? HOUR_MAX : MINSEC_MAX;

  // Event priority inside an entry state: sharp, then star, then digit.
  always_comb begin
    nxt_state = state;
    nxt_ten   = cur_ten;
    nxt_one   = cur_one;
    nxt_count = count;
    evt       = 1'b0;
    err_set   = 1'b0;
    restore   = 1'b0;
    field     = FLD_NONE;
    busy      = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        nxt_count = 2'd0;
        if (en) nxt_state = ST_HOUR;
      end
      ST_HOUR, ST_MIN, ST_SEC: begin
        busy  = 1'b1;
        field = (state == ST_HOUR) ? FLD_HOUR : (state == ST_MIN) ? FLD_MIN : FLD_SEC;
        if (sharp_p) begin
          evt       = 1'b1;
          nxt_count = 2'd0;
          if (val <= limit) begin
            nxt_state = (state == ST_HOUR) ? ST_MIN : (state == ST_MIN) ? ST_SEC : ST_COMMIT;
          end else begin
            err_set = 1'b1;
            nxt_ten = 4'd0;
            nxt_one = 4'd0;
          end
        end else if (star_p) begin
          evt       = 1'b1;
          nxt_ten   = 4'd0;
          nxt_one   = 4'd0;
          nxt_count = 2'd0;
        end else if (key_p) begin
          evt       = 1'b1;
          nxt_ten   = (count == 2'd0) ? 4'd0 : cur_one;
          nxt_one   = onehot_to_bcd(keypad);
          nxt_count = (count == 2'd2) ? 2'd2 : count + 2'd1;
        end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          restore   = 1'b1;
          nxt_state = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        busy      = 1'b1;
        load      = 1'b1;
        nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      tmo   <= '0;
      err   <= 1'b0;
      {hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one} <= '0;
      {sh_hour_ten, sh_hour_one, sh_min_ten, sh_min_one, sh_sec_ten, sh_sec_one} <= '0;
    end else begin
      count <= nxt_count;
      err   <= err_set;
      // Counter only advances while waiting for input in an entry state.
      if (evt || state == ST_IDLE || state == ST_COMMIT) tmo <= '0;
      else                                               tmo <= tmo + TW'(1);
      case (state)
        ST_HOUR: begin hour_ten <= nxt_ten; hour_one <= nxt_one; end
        ST_MIN:  begin min_ten  <= nxt_ten; min_one  <= nxt_one; end
        ST_SEC:  begin sec_ten  <= nxt_ten; sec_one  <= nxt_one; end
        default: ;
      endcase
      if (restore)
        {hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one} <=
          {sh_hour_ten, sh_hour_one, sh_min_ten, sh_min_one, sh_sec_ten, sh_sec_one};
      if (state == ST_COMMIT)
        {sh_hour_ten, sh_hour_one, sh_min_ten, sh_min_one, sh_sec_ten, sh_sec_one} <=
          {hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one};
    end
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl: entry, rejection, clear, timeout,
// priority and mid-session reset.
module tb_time_entry_ctrl;

  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [9:0] keypad = '0;
  logic       sharp = 1'b0;
  logic       star = 1'b0;
  logic [3:0] hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one;
  logic [1:0] field;
  logic       busy, load, err;

  int checks = 0;
  int failures = 0;
  int load_seen;

  time_entry_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .keypad(keypad), .sharp(sharp), .star(star),
    .hour_ten(hour_ten), .hour_one(hour_one), .min_ten(min_ten), .min_one(min_one),
    .sec_ten(sec_ten), .sec_one(sec_one), .field(field), .busy(busy), .load(load), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] digits();
    return {hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    keypad = 10'(1 << d);
    tick();
    keypad = '0;
    tick();
  endtask

  task automatic confirm();
    sharp = 1'b1;
    tick();
    sharp = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_digits", 32'(digits()), 32'h000000);
    chk("rst_field", 32'(field), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_err", 32'({load, err}), 32'd0);
    rst = 1'b0;
    tick();

    // Happy path 12:34:56
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("en_busy", 32'(busy), 32'd1);
    chk("en_field", 32'(field), 32'd0);
    press(1);
    chk("hour_1", 32'(digits()), 32'h010000);
    press(2);
    chk("hour_12", 32'(digits()), 32'h120000);
    confirm();
    chk("to_min", 32'(field), 32'd1);
    press(3); press(4); confirm();
    chk("to_sec", 32'(field), 32'd2);
    press(5); press(6);
    chk("sec_56", 32'(digits()), 32'h123456);
    sharp = 1'b1;
    tick();
    sharp = 1'b0;
    chk("commit_load", 32'(load), 32'd1);
    chk("commit_digits", 32'(digits()), 32'h123456);
    tick();
    chk("commit_load_end", 32'(load), 32'd0);
    chk("commit_idle", 32'({busy, field}), 32'({1'b0, 2'd3}));

    // Range rejection on hour 25, then 09 accepted
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("reentry_staged", 32'(digits()), 32'h123456);
    press(2); press(5);
    sharp = 1'b1;
    tick();
    sharp = 1'b0;
    chk("reject_err", 32'(err), 32'd1);
    chk("reject_cleared", 32'(digits()), 32'h003456);
    chk("reject_field", 32'(field), 32'd0);
    tick();
    chk("reject_err_pulse", 32'(err), 32'd0);
    press(0); press(9); confirm();
    chk("hour09_field", 32'(field), 32'd1);
    chk("hour09_digits", 32'(digits()), 32'h093456);

    // Shift and clear in minutes
    press(1); press(2); press(3);
    chk("min_shift", 32'(digits()), 32'h092356);
    star = 1'b1;
    tick();
    star = 1'b0;
    tick();
    chk("min_star", 32'(digits()), 32'h090056);
    press(4); confirm();
    chk("min04_field", 32'(field), 32'd2);
    chk("min04_digits", 32'(digits()), 32'h090456);
    sharp = 1'b1;
    tick();
    sharp = 1'b0;
    chk("sec_keep_load", 32'({load, digits()}), 32'({1'b1, 24'h090456}));
    tick();

    // Commit 07:00:00 as the reference for the timeout test
    en = 1'b1;
    tick();
    en = 1'b0;
    press(0); press(7); confirm();
    press(0); confirm();
    press(0);
    sharp = 1'b1;
    tick();
    sharp = 1'b0;
    chk("commit0700", 32'({load, digits()}), 32'({1'b1, 24'h070000}));
    tick();

    // Timeout: one digit then silence
    en = 1'b1;
    tick();
    en = 1'b0;
    press(1);
    chk("tmo_staged", 32'(digits()), 32'h010000);
    load_seen = 0;
    for (int i = 0; i < TMO - 2; i++) begin
      tick();
      if (load) load_seen++;
    end
    chk("tmo_not_yet", 32'({busy, digits()}), 32'({1'b1, 24'h010000}));
    tick();
    if (load) load_seen++;
    chk("tmo_restored", 32'(digits()), 32'h070000);
    chk("tmo_idle", 32'({busy, field}), 32'({1'b0, 2'd3}));
    chk("tmo_no_load", 32'(load_seen), 32'd0);

    // Simultaneity: sharp beats digit, two-hot ignored, sharp beats star
    en = 1'b1;
    tick();
    en = 1'b0;
    keypad = 10'(1 << 5);
    sharp = 1'b1;
    tick();
    keypad = '0;
    sharp = 1'b0;
    chk("sharp_over_digit", 32'({field, digits()}), 32'({2'd1, 24'h070000}));
    tick();
    keypad = 10'b0000011000;
    tick();
    keypad = '0;
    tick();
    chk("twohot_ignored", 32'(digits()), 32'h070000);
    press(8);
    chk("after_twohot", 32'(digits()), 32'h070800);
    sharp = 1'b1;
    star = 1'b1;
    tick();
    sharp = 1'b0;
    star = 1'b0;
    chk("sharp_over_star", 32'({field, digits()}), 32'({2'd2, 24'h070800}));
    tick();

    // Reset mid-entry in SEC
    press(3);
    chk("sec_before_rst", 32'(digits()), 32'h070803);
    rst = 1'b1;
    #1;
    chk("rst_async_digits", 32'(digits()), 32'h000000);
    chk("rst_async_ctrl", 32'({busy, field, load, err}), 32'({1'b0, 2'd3, 1'b0, 1'b0}));
    tick();
    rst = 1'b0;
    tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("post_rst_session", 32'({field, digits()}), 32'({2'd0, 24'h000000}));
    press(2); confirm(); confirm();
    sharp = 1'b1;
    tick();
    sharp = 1'b0;
    chk("post_rst_commit", 32'({load, digits()}), 32'({1'b1, 24'h020000}));
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
